// File: rtl/lp_filter_cascade_mc.sv
// Multi-channel cascaded first-order IIR low-pass filter.
// One shared update datapath walks the stages of the latched channel, one stage per cycle.

module lp_filter_chan_state #(
    parameter int STAGES        = 2,
    parameter int INTERNAL_BITS = 36,
    parameter int KW            = 1
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  we,
    input  logic [KW-1:0]                         k,
    input  logic [INTERNAL_BITS-1:0]              wdata,
    output logic [STAGES-1:0][INTERNAL_BITS-1:0]  st
);
    always_ff @(posedge CLK) begin
        if (RESET) begin
            st <= '0;
        end else if (we) begin
            for (int j = 0; j < STAGES; j++)
                if (k == KW'(j)) st[j] <= wdata;
        end
    end
endmodule

module lp_filter_cascade_mc #(
    parameter int IN_DATA_BITS   = 30,
    parameter int SHIFT_BITS     = 6,
    parameter int OUT_DATA_BITS  = 33,
    parameter int CHANNELS       = 4,
    parameter int CH_BITS        = 2,
    parameter int STAGES         = 2,
    parameter int SHIFT_SEL_BITS = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      CE,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [CH_BITS-1:0]        IN_CHANNEL,
    input  logic [IN_DATA_BITS-1:0]   IN_VALUE,
    input  logic                      IN_LOAD,
    input  logic [SHIFT_SEL_BITS-1:0] SHIFT,
    output logic                      OUT_VALID,
    output logic [CH_BITS-1:0]        OUT_CHANNEL,
    output logic [OUT_DATA_BITS-1:0]  OUT_VALUE
);
    localparam int INTERNAL_BITS = IN_DATA_BITS + SHIFT_BITS;
    localparam int KW            = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int SW            = $clog2(SHIFT_BITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    typedef struct packed {
        logic [CH_BITS-1:0]      ch;
        logic                    ch_ok;
        logic [IN_DATA_BITS-1:0] value;
        logic                    load;
        logic [SW-1:0]           s;
    } req_t;

    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    req_t req_q, req_in;
    logic accept, last;
    int   sh;

    logic [CHANNELS-1:0][STAGES-1:0][INTERNAL_BITS-1:0] st_all;
    logic [STAGES-1:0][INTERNAL_BITS-1:0]               sel;
    logic [INTERNAL_BITS-1:0]                           cur, prev, nxt;
    logic [IN_DATA_BITS-1:0]                            x;
    logic signed [INTERNAL_BITS:0]                      diff, inc;
    logic [CHANNELS-1:0]                                we_ch;
    logic                                               unused_bits;

    assign IN_READY = (state_q == IDLE) & CE & ~RESET;
    assign accept   = IN_VALID & IN_READY;
    assign last     = (k_q == KW'(STAGES - 1));

    // Shift is clamped once at accept so the datapath only sees legal values.
    always_comb begin
        sh = int'(SHIFT);
        if (sh < 1) sh = 1;
        if (sh > SHIFT_BITS) sh = SHIFT_BITS;
        req_in       = '0;
        req_in.ch    = IN_CHANNEL;
        req_in.ch_ok = (int'(IN_CHANNEL) < CHANNELS);
        req_in.value = IN_VALUE;
        req_in.load  = IN_LOAD;
        req_in.s     = SW'(sh);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = RUN;
                k_d     = '0;
            end
            RUN: if (last) state_d = OUT;
                 else      k_d     = k_q + 1'b1;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            k_q     <= '0;
            req_q   <= '0;
        end else if (CE) begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) req_q <= req_in;
        end
    end

    // Stage k reads its own state and the already-updated stage k-1.
    always_comb begin
        sel = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (req_q.ch == CH_BITS'(c)) sel = st_all[c];
        cur  = '0;
        prev = '0;
        for (int j = 0; j < STAGES; j++)
            if (k_q == KW'(j)) cur = sel[j];
        for (int j = 1; j < STAGES; j++)
            if (k_q == KW'(j)) prev = sel[j-1];
    end

    assign x    = (k_q == '0) ? req_q.value : prev[INTERNAL_BITS-1:SHIFT_BITS];
    assign diff = {1'b0, x, {SHIFT_BITS{1'b0}}} - {1'b0, cur};
    assign inc  = diff >>> req_q.s;
    assign nxt  = req_q.load ? {req_q.value, {SHIFT_BITS{1'b0}}}
                             : cur + inc[INTERNAL_BITS-1:0];
    assign unused_bits = ^{inc[INTERNAL_BITS], prev[SHIFT_BITS-1:0]};

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign we_ch[c] = CE & (state_q == RUN) & req_q.ch_ok & (req_q.ch == CH_BITS'(c));
        lp_filter_chan_state #(
            .STAGES(STAGES), .INTERNAL_BITS(INTERNAL_BITS), .KW(KW)
        ) u_st (
            .CLK   (CLK),
            .RESET (RESET),
            .we    (we_ch[c]),
            .k     (k_q),
            .wdata (nxt),
            .st    (st_all[c])
        );
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OUT_VALID   <= 1'b0;
            OUT_CHANNEL <= '0;
            OUT_VALUE   <= '0;
        end else if (CE) begin
            OUT_VALID <= 1'b0;
            if (state_q == RUN && last && req_q.ch_ok) begin
                OUT_VALID   <= 1'b1;
                OUT_CHANNEL <= req_q.ch;
                OUT_VALUE   <= nxt[INTERNAL_BITS-1:INTERNAL_BITS-OUT_DATA_BITS];
            end
        end
    end
endmodule

// File: tb/tb_lp_filter_cascade_mc.sv
// Randomized bench for lp_filter_cascade_mc against a per-channel arithmetic reference model.

module tb_lp_filter_cascade_mc;
    localparam int IB = 30, SB = 6, OB = 33, STG = 2;
    localparam longint SC = 64, OD = 8;

    logic        CLK = 1'b0;
    logic        RESET, CE, IN_VALID, IN_LOAD;
    logic [1:0]  IN_CHANNEL;
    logic [29:0] IN_VALUE;
    logic [2:0]  SHIFT;
    logic        IN_READY, OUT_VALID;
    logic [1:0]  OUT_CHANNEL;
    logic [32:0] OUT_VALUE;
    logic        r3_ready, r3_valid;
    logic [1:0]  r3_ch;
    logic [32:0] r3_value;

    int n_chk = 0, n_fail = 0;
    longint mst [4][STG];

    always #5 CLK = ~CLK;

    lp_filter_cascade_mc dut (
        .CLK(CLK), .RESET(RESET), .CE(CE), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_CHANNEL(IN_CHANNEL), .IN_VALUE(IN_VALUE), .IN_LOAD(IN_LOAD), .SHIFT(SHIFT),
        .OUT_VALID(OUT_VALID), .OUT_CHANNEL(OUT_CHANNEL), .OUT_VALUE(OUT_VALUE)
    );

    lp_filter_cascade_mc #(.CHANNELS(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .CE(CE), .IN_VALID(IN_VALID), .IN_READY(r3_ready),
        .IN_CHANNEL(IN_CHANNEL), .IN_VALUE(IN_VALUE), .IN_LOAD(IN_LOAD), .SHIFT(SHIFT),
        .OUT_VALID(r3_valid), .OUT_CHANNEL(r3_ch), .OUT_VALUE(r3_value)
    );

    task automatic chk(input string tag, input longint got, input longint ev);
        n_chk++;
        if (got !== ev) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, ev);
        end
    endtask

    function automatic longint fdiv(longint a, int s);
        longint p;
        p = longint'(1) << s;
        if (a >= 0) return a / p;
        return -((-a + p - 1) / p);
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < STG; k++) mst[c][k] = 0;
    endfunction

    // Each stage moves 1/2**s of the way toward its input, rounding down.
    function automatic longint model(int ch, longint val, bit load, int shift);
        int s;
        longint x;
        s = (shift < 1) ? 1 : ((shift > SB) ? SB : shift);
        for (int k = 0; k < STG; k++) begin
            if (load) mst[ch][k] = val * SC;
            else begin
                x = (k == 0) ? val : mst[ch][k-1] / SC;
                mst[ch][k] = mst[ch][k] + fdiv(x * SC - mst[ch][k], s);
            end
        end
        return mst[ch][STG-1] / OD;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        model_clear();
    endtask

    task automatic send(input int ch, input longint val, input bit load, input int shift,
                        input int ce_gap, input bit rst_mid, output longint got);
        int w, lat, co;
        bit seen, seen3;
        longint vo, v3, ev;
        got = -1;
        @(negedge CLK);
        IN_VALID = 1'b1; IN_CHANNEL = 2'(ch); IN_VALUE = 30'(val);
        IN_LOAD = load; SHIFT = 3'(shift);
        w = 0;
        while (!IN_READY && w < 20) begin @(negedge CLK); w++; end
        if (!IN_READY) begin
            chk("accept_timeout", 0, 1);
            IN_VALID = 1'b0;
            return;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        ev = model(ch, val, load, shift);
        seen = 0; seen3 = 0; lat = 0; vo = 0; co = 0; v3 = 0;
        for (int n = 1; n <= STG + 3 + ce_gap; n++) begin
            if (seen && n == lat + 1) chk("pulse_width", OUT_VALID, 0);
            if (OUT_VALID && !seen) begin seen = 1; lat = n; vo = OUT_VALUE; co = OUT_CHANNEL; end
            if (r3_valid && !seen3) begin seen3 = 1; v3 = r3_value; end
            if (n <= STG + 1) chk("ready_busy", IN_READY, 0);
            if (rst_mid && n == 1) RESET = 1'b1;
            if (rst_mid && n == 3) RESET = 1'b0;
            if (ce_gap > 0 && n == 1) CE = 1'b0;
            if (ce_gap > 0 && n == 1 + ce_gap) CE = 1'b1;
            @(negedge CLK);
        end
        if (rst_mid) begin
            chk("rst_no_valid", seen, 0);
            model_clear();
        end else begin
            chk("latency", lat, STG + 1 + ce_gap);
            chk("out_value", vo, ev);
            chk("out_channel", co, ch);
            got = vo;
        end
        if (ch >= 3) chk("c3_no_valid", seen3, 0);
        else if (!rst_mid) chk("c3_value", v3, ev);
    endtask

    initial begin
        longint got, prev;
        RESET = 1'b1; CE = 1'b1; IN_VALID = 1'b0; IN_CHANNEL = '0;
        IN_VALUE = '0; IN_LOAD = 1'b0; SHIFT = 3'd6;
        model_clear();
        repeat (3) @(negedge CLK);
        chk("rst_ready", IN_READY, 0);
        chk("rst_valid", OUT_VALID, 0);
        chk("rst_value", OUT_VALUE, 0);
        chk("rst_channel", OUT_CHANNEL, 0);
        RESET = 1'b0;
        @(negedge CLK);
        chk("ready_idle", IN_READY, 1);

        send(0, 1000, 0, 6, 0, 0, got);   chk("t1_value", got, 1);
        send(1, 1000, 1, 6, 0, 0, got);   chk("t2_load", got, 8000);
        send(1, 1000, 0, 6, 0, 0, got);   chk("t2_hold", got, 8000);

        do_reset();
        send(2, 1000, 0, 0, 0, 0, got);   chk("t3_shift0", got, 2000);
        do_reset();
        send(2, 1000, 0, 7, 0, 0, got);   chk("t3_shift7", got, 1);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(2, 1000, 0, 6, 0, 0, got);
            send(3, 0, 0, 6, 0, 0, got);  chk("t4_ch3_zero", got, 0);
        end

        send(0, 5000, 0, 3, 5, 0, got);
        send(0, 777, 0, 6, 0, 1, got);
        send(0, 1000, 0, 6, 0, 0, got);   chk("t6_after_rst", got, 1);

        for (int i = 0; i < 300; i++) begin
            int ch, sh, gap;
            longint v;
            bit ld;
            ch  = $urandom_range(0, 3);
            sh  = $urandom_range(0, 7);
            ld  = ($urandom_range(0, 7) == 0);
            v   = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 5000))
                                              : longint'($urandom & 32'h3fff_ffff);
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
            send(ch, v, ld, sh, gap, 0, got);
        end

        do_reset();
        prev = 0;
        for (int i = 0; i < 2000; i++) begin
            send(1, (longint'(1) << IB) - 1, 0, 6, 0, 0, got);
            chk("mono", (got >= prev) ? 1 : 0, 1);
            prev = got;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
